// File: rtl/seven_seg_scanner.sv
// Multiplexed BCD seven-segment scanner with a per-frame shadow register,
// one dark cycle per digit slot for anti-ghosting, and leading-zero blanking.
module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter bit COMMON_ANODE = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [NUM_DIGITS*4-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    blank_lz,
    output logic [6:0]              seg_n,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int PCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [6:0]            SEG_OFF = {7{COMMON_ANODE}};
    localparam logic                  DP_OFF  = COMMON_ANODE;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{COMMON_ANODE}};

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'd0:    g = 7'h3F;
            4'd1:    g = 7'h06;
            4'd2:    g = 7'h5B;
            4'd3:    g = 7'h4F;
            4'd4:    g = 7'h66;
            4'd5:    g = 7'h6D;
            4'd6:    g = 7'h7D;
            4'd7:    g = 7'h07;
            4'd8:    g = 7'h7F;
            4'd9:    g = 7'h6F;
            default: g = 7'h40;
        endcase
        return g;
    endfunction

    // Bit i set when digit i and every more-significant digit are zero; digit 0 never blanks.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [NUM_DIGITS*4-1:0] d,
                                                      input logic                    en);
        logic [NUM_DIGITS-1:0] m;
        logic                  run;
        m   = '0;
        run = en;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run  = run & (d[i*4 +: 4] == 4'd0);
            m[i] = run;
        end
        return m;
    endfunction

    logic [PCNT_W-1:0]       pcnt_q, pcnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_DIGITS*4-1:0] dig_sh_q;
    logic [NUM_DIGITS-1:0]   dpm_sh_q;
    logic                    blz_sh_q;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_q, frame_d;

    logic                    pcnt_last, idx_last, shadow_load;
    logic [NUM_DIGITS-1:0]   blank_vec;
    logic [3:0]              cur_dig;
    logic                    cur_dpm, cur_blank;
    logic [6:0]              seg_act;
    logic                    dp_act;
    logic [NUM_DIGITS-1:0]   an_act;

    assign pcnt_last   = (pcnt_q == PCNT_W'(REFRESH_DIV - 1));
    assign idx_last    = (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign shadow_load = (pcnt_q == '0) && (idx_q == '0);
    assign blank_vec   = lz_mask(dig_sh_q, blz_sh_q);

    always_comb begin
        pcnt_d  = pcnt_last ? '0 : pcnt_q + 1'b1;
        idx_d   = idx_q;
        if (pcnt_last) begin
            idx_d = idx_last ? '0 : idx_q + 1'b1;
        end
        frame_d = pcnt_last && idx_last;
    end

    // Display path works from the current (idx, pcnt); the result is registered,
    // so outputs trail the scan state by one clock.
    always_comb begin
        cur_dig   = 4'd0;
        cur_dpm   = 1'b0;
        cur_blank = 1'b0;
        an_act    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_dig   = dig_sh_q[i*4 +: 4];
                cur_dpm   = dpm_sh_q[i];
                cur_blank = blank_vec[i];
                an_act[i] = 1'b1;
            end
        end
        seg_act = cur_blank ? 7'h00 : glyph(cur_dig);
        dp_act  = cur_dpm & ~cur_blank;
        if (pcnt_q == '0) begin
            seg_act = 7'h00;
            dp_act  = 1'b0;
            an_act  = '0;
        end
        seg_d = seg_act ^ SEG_OFF;
        dp_d  = dp_act ^ DP_OFF;
        an_d  = an_act ^ AN_OFF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q   <= '0;
            idx_q    <= '0;
            dig_sh_q <= '0;
            dpm_sh_q <= '0;
            blz_sh_q <= 1'b0;
            seg_q    <= SEG_OFF;
            dp_q     <= DP_OFF;
            an_q     <= AN_OFF;
            frame_q  <= 1'b0;
        end else if (enable) begin
            pcnt_q  <= pcnt_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            frame_q <= frame_d;
            if (shadow_load) begin
                dig_sh_q <= digits;
                dpm_sh_q <= dp_mask;
                blz_sh_q <= blank_lz;
            end
        end else begin
            seg_q   <= SEG_OFF;
            dp_q    <= DP_OFF;
            an_q    <= AN_OFF;
            frame_q <= 1'b0;
        end
    end

    assign seg_n      = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner (4 digits, 4-cycle slots, common anode):
// directed table vectors, corner sequences and random stimulus against a frame-count model.
module tb_seven_seg_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dp_mask = '0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg_n;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    seven_seg_scanner #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .COMMON_ANODE(1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .digits    (digits),
        .dp_mask   (dp_mask),
        .blank_lz  (blank_lz),
        .seg_n     (seg_n),
        .dp        (dp),
        .an        (an),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph_t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    // Model: k counts enabled edges since reset; slot = k/4, pcnt = k%4, frame = k/16.
    int          k;
    logic [15:0] sh_dig;
    logic [3:0]  sh_dpm;
    logic        sh_blz;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic        exp_fd;

    task automatic model_reset();
        k = 0; sh_dig = '0; sh_dpm = '0; sh_blz = 1'b0;
        exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0;
    endtask

    task automatic model_edge();
        int p, d;
        logic blanked;
        if (!enable) begin
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0;
        end else begin
            if (k % 16 == 0) begin
                sh_dig = digits; sh_dpm = dp_mask; sh_blz = blank_lz;
            end
            p = k % 4;
            d = (k / 4) % 4;
            if (p == 0) begin
                exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
            end else begin
                blanked = sh_blz && (d > 0) && ((sh_dig >> (d * 4)) == 16'h0);
                exp_seg = ~(blanked ? 7'h00 : glyph_t[sh_dig[d*4 +: 4]]);
                exp_dp  = ~(sh_dpm[d] && !blanked);
                exp_an  = ~(4'b0001 << d);
            end
            exp_fd = (k % 16 == 15);
            k++;
        end
    endtask

    task automatic check_model(input string name);
        checks++;
        if ({an, seg_n, dp, frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
            errors++;
            $display("FAIL %s k=%0d: got an=%h seg_n=%h dp=%b fd=%b, want an=%h seg_n=%h dp=%b fd=%b",
                     name, k, an, seg_n, dp, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
        end
    endtask

    task automatic check_out(input string name, input logic [3:0] w_an, input logic [6:0] w_seg,
                             input logic w_dp, input logic w_fd);
        checks++;
        if ({an, seg_n, dp, frame_done} !== {w_an, w_seg, w_dp, w_fd}) begin
            errors++;
            $display("FAIL %s: got an=%h seg_n=%h dp=%b fd=%b, want an=%h seg_n=%h dp=%b fd=%b",
                     name, an, seg_n, dp, frame_done, w_an, w_seg, w_dp, w_fd);
        end
    endtask

    task automatic step(input string name);
        model_edge();
        @(posedge clk);
        #1;
        check_model(name);
    endtask

    // Called 1 time unit after a rising edge; pulse stays clear of the next edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1 check_out("async_reset", 4'hF, 7'h7F, 1'b1, 1'b0);
        model_reset();
        #2 rst = 1'b0;
    endtask

    typedef struct {
        logic [15:0] dig;
        logic [3:0]  dpm;
        logic        blz;
        int          slot;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
    } vec_t;

    vec_t vt [12];

    initial begin
        vt[0]  = '{16'h1234, 4'h0, 1'b0, 0, 4'hE, 7'h19, 1'b1};
        vt[1]  = '{16'h1234, 4'h0, 1'b0, 1, 4'hD, 7'h30, 1'b1};
        vt[2]  = '{16'h1234, 4'h0, 1'b0, 2, 4'hB, 7'h24, 1'b1};
        vt[3]  = '{16'h1234, 4'h0, 1'b0, 3, 4'h7, 7'h79, 1'b1};
        vt[4]  = '{16'h0050, 4'h2, 1'b1, 3, 4'h7, 7'h7F, 1'b1};
        vt[5]  = '{16'h0050, 4'h2, 1'b1, 2, 4'hB, 7'h7F, 1'b1};
        vt[6]  = '{16'h0050, 4'h2, 1'b1, 1, 4'hD, 7'h12, 1'b0};
        vt[7]  = '{16'h0050, 4'h2, 1'b1, 0, 4'hE, 7'h40, 1'b1};
        vt[8]  = '{16'h00A0, 4'h0, 1'b0, 1, 4'hD, 7'h3F, 1'b1};
        vt[9]  = '{16'h0000, 4'hF, 1'b1, 0, 4'hE, 7'h40, 1'b0};
        vt[10] = '{16'h0000, 4'hF, 1'b1, 1, 4'hD, 7'h7F, 1'b1};
        vt[11] = '{16'h1009, 4'h0, 1'b1, 2, 4'hB, 7'h40, 1'b1};

        model_reset();
        repeat (2) @(posedge clk);
        #1 check_out("reset_state", 4'hF, 7'h7F, 1'b1, 1'b0);
        #2 rst = 1'b0;
        enable = 1'b1;

        // Table vectors: reset, load, then compare the first lit cycle of the chosen slot.
        for (int v = 0; v < 12; v++) begin
            digits = vt[v].dig; dp_mask = vt[v].dpm; blank_lz = vt[v].blz;
            do_reset();
            for (int s = 0; s <= 4 * vt[v].slot + 1; s++) step("vec_model");
            checks++;
            if ({an, seg_n, dp} !== {vt[v].an, vt[v].seg, vt[v].dp}) begin
                errors++;
                $display("FAIL vec%0d: got an=%h seg_n=%h dp=%b, want an=%h seg_n=%h dp=%b",
                         v, an, seg_n, dp, vt[v].an, vt[v].seg, vt[v].dp);
            end
        end

        // Full frame plus wrap: dark cycles and frame_done pulse spacing.
        digits = 16'h1234; dp_mask = 4'h0; blank_lz = 1'b0;
        do_reset();
        for (int s = 0; s < 40; s++) step("frame_seq");

        // Input change mid-frame must wait for the next shadow load.
        do_reset();
        for (int s = 0; s < 10; s++) step("coherent_a");
        digits = 16'h5678;
        for (int s = 10; s < 14; s++) step("coherent_b");
        check_out("old_frame_digit3", 4'h7, 7'h79, 1'b1, 1'b0);
        for (int s = 14; s < 18; s++) step("coherent_c");
        check_out("new_frame_digit0", 4'hE, 7'h00, 1'b1, 1'b0);

        // Pause in slot 1 at pcnt=2, then resume.
        digits = 16'h1234;
        do_reset();
        for (int s = 0; s < 6; s++) step("pause_a");
        enable = 1'b0;
        step("pause_b");
        check_out("pause_dark", 4'hF, 7'h7F, 1'b1, 1'b0);
        for (int s = 0; s < 9; s++) step("pause_hold");
        enable = 1'b1;
        step("resume");
        check_out("resume_slot1", 4'hD, 7'h30, 1'b1, 1'b0);
        for (int s = 0; s < 12; s++) step("resume_tail");

        // Reset in the middle of a lit slot, then restart from digit 0.
        for (int s = 0; s < 5; s++) step("mid_a");
        do_reset();
        for (int s = 0; s < 6; s++) step("mid_restart");

        // Every nybble value through digit 0.
        for (int v = 0; v < 16; v++) begin
            digits = 16'(v); dp_mask = 4'h0; blank_lz = 1'b0;
            do_reset();
            step("sweep_dark");
            step("sweep_lit");
            check_out($sformatf("glyph_%0h", v), 4'hE, ~glyph_t[v], 1'b1, 1'b0);
        end

        // Random inputs, enable drops and an occasional reset.
        do_reset();
        for (int s = 0; s < 600; s++) begin
            for (int i = 0; i < 4; i++)
                digits[i*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            dp_mask  = 4'($urandom_range(0, 15));
            blank_lz = 1'($urandom_range(0, 1));
            enable   = ($urandom_range(0, 7) != 0);
            if (s == 300) do_reset();
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of BCD digits scanned (range 1..8).
REQ-002 Parameter REFRESH_DIV, default 100000, clk cycles per digit slot (minimum 2).
REQ-003 Parameter COMMON_ANODE, default 1; 1 = seg_n, dp, an active-low; 0 = active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 enable  input  1  scanning enabled; low = display dark, scan state frozen.
REQ-007 digits  input  NUM_DIGITS*4  packed BCD; nybble i = digit i; digit 0 = least significant, rightmost.
REQ-008 dp_mask  input  NUM_DIGITS  bit i lights decimal point of digit i.
REQ-009 blank_lz  input  1  leading-zero blanking enable.
REQ-010 seg_n  output  7  segments a..g, bit0 = a, bit6 = g, registered.
REQ-011 dp  output  1  decimal point, registered.
REQ-012 an  output  NUM_DIGITS  digit select, bit i = digit i, registered, at most one active.
REQ-013 frame_done  output  1  one-cycle pulse per completed scan frame, registered.

Function
REQ-014 Prescaler pcnt SHALL count 0..REFRESH_DIV-1 and wrap to 0 on clk while enable=1, and hold while enable=0.
REQ-015 Scan index idx SHALL advance on the edge where pcnt wraps, order 0,1,...,NUM_DIGITS-1, then wrap to 0.
REQ-016 Shadow register SHALL load digits, dp_mask and blank_lz on every enabled edge with idx=0 and pcnt=0; shadow is the only source for display, so a frame is coherent.
REQ-017 Input changes at any other time SHALL NOT affect display until the next shadow load.
REQ-018 Dead time: for the first cycle of each slot (pcnt=0), the registered outputs SHALL all be inactive (anti-ghosting).
REQ-019 For pcnt in 1..REFRESH_DIV-1, the registered outputs SHALL assert an[idx] only and drive seg_n/dp from shadow digit idx; outputs lag (idx,pcnt) by exactly one clock.
REQ-020 Glyphs, active-high form bit6..bit0 = g..a: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; nybble A..F = 40 (segment g only, error marker).
REQ-021 When COMMON_ANODE=1, seg_n, dp and an SHALL be bitwise inverted from active-high form.
REQ-022 Leading-zero blanking: when shadow blank_lz=1, digit i (i>0) SHALL have all segments and dp off if shadow digits NUM_DIGITS-1 down to i are all 0; an[i] still asserted; digit 0 never blanked.
REQ-023 dp SHALL be active when shadow dp_mask[idx]=1 and the digit is not blanked.
REQ-024 enable=0 SHALL drive all outputs inactive from the next clock and freeze pcnt, idx and shadow; re-enable resumes at the held pcnt/idx.
REQ-025 frame_done SHALL be high for exactly one cycle, on the cycle following the edge where idx wraps NUM_DIGITS-1 -> 0; never asserted while enable=0.
REQ-026 NUM_DIGITS=1: idx stays 0, frame_done pulses once per slot.

Reset
REQ-027 rst SHALL clear pcnt, idx, shadow (digits 0, dp_mask 0, blank_lz 0) and frame_done immediately, regardless of clk.
REQ-028 During reset, an, seg_n and dp SHALL be inactive (COMMON_ANODE=1: an=all ones, seg_n=7F, dp=1).
REQ-029 rst mid-slot SHALL abort the slot; after release, first enabled edge starts slot idx=0 with a shadow load.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, COMMON_ANODE=1)
REQ-030 rst pulse mid-scan -> an=F, seg_n=7F, dp=1, frame_done=0 asynchronously; scan restarts at digit 0.
REQ-031 digits=1234, dp_mask=0, blank_lz=0 -> per 4-cycle slot: 1 dark cycle, then 3 cycles an=E seg_n=19 ('4'), then an=D seg_n=30 ('3'), an=B seg_n=24 ('2'), an=7 seg_n=79 ('1'); frame_done pulse every 16 cycles.
REQ-032 digits=0050, blank_lz=1, dp_mask=0010 -> digit3 and digit2 seg_n=7F dp=1 with an asserted; digit1 seg_n=12 dp=0; digit0 seg_n=40.
REQ-033 digits changed 1234 -> 5678 during slot 2 -> remainder of frame shows 1234; 5678 appears from next frame.
REQ-034 enable low for 10 cycles in slot 1 pcnt=2 -> an=F next clock, no frame_done; after re-enable, slot 1 continues from pcnt=2 with lit outputs one clock later.
REQ-035 digits=00A0 -> digit1 seg_n=3F (segment g only); all 16 values 0..F swept through digit 0 match REQ-020.
